// File: rtl/clock_panel_ctrl.sv
// clock_panel_ctrl: front-panel controller for the processor clock divider.
// Debounces the panel buttons, cycles the divider frequency select, runs the
// RUN / HALTED / single-step FSM using clk_out as feedback, and generates the
// divider/processor reset pulse.
module clock_panel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter logic [1:0]  FREQ_INIT        = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_freq,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_rst,
    input  logic       cpu_halt,
    input  logic       clk_out,
    output logic [1:0] freq,
    output logic [1:0] Halt,
    output logic       div_reset,
    output logic       running,
    output logic       stepping
);

    localparam int unsigned NBTN     = 4;
    localparam int unsigned BTN_FREQ = 0;
    localparam int unsigned BTN_RUN  = 1;
    localparam int unsigned BTN_STEP = 2;
    localparam int unsigned BTN_RST  = 3;
    localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RP_W     = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RST_PULSE_CYCLES - 1);
    localparam logic [1:0] HALT_RUN  = 2'b00;
    localparam logic [1:0] HALT_HOLD = 2'b10;

    typedef enum logic [1:0] {
        S_HALTED    = 2'b00,
        S_RUN       = 2'b01,
        S_STEP_FALL = 2'b10,
        S_STEP_RISE = 2'b11
    } state_t;

    logic [NBTN-1:0] w_btn_raw;
    logic [NBTN-1:0] w_btn_pulse;
    logic            w_freq_p;
    logic            w_run_p;
    logic            w_step_p;
    logic            w_rst_p;
    logic            w_halt_s;
    logic            w_clk_s;

    logic [1:0]      r_fb_s1;
    logic [1:0]      r_fb_s2;
    logic [RP_W-1:0] r_rp_cnt;
    logic            r_div_reset;
    logic [1:0]      r_freq;
    state_t          r_state;
    logic [1:0]      r_halt;
    logic            r_running;
    logic            r_stepping;

    assign w_btn_raw = {btn_rst, btn_step, btn_run, btn_freq};

    // Per-button synchronizer, debounce counter and rising-edge pulse
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        logic            r_s1;
        logic            r_s2;
        logic            r_acc;
        logic            r_acc_d;
        logic [DB_W-1:0] r_cnt;

        // Synchronize, then accept the level once it has differed for DEBOUNCE_CYCLES cycles
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_acc   <= 1'b0;
                r_acc_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_btn_raw[g];
                r_s2    <= r_s1;
                r_acc_d <= r_acc;
                if (r_s2 == r_acc) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_cnt <= '0;
                    r_acc <= r_s2;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        assign w_btn_pulse[g] = r_acc & ~r_acc_d;
    end

    assign w_freq_p = w_btn_pulse[BTN_FREQ];
    assign w_run_p  = w_btn_pulse[BTN_RUN];
    assign w_step_p = w_btn_pulse[BTN_STEP];
    assign w_rst_p  = w_btn_pulse[BTN_RST];

    // Two-flop synchronizers for the fed-back divider clock and the processor halt level
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fb_s1 <= '0;
            r_fb_s2 <= '0;
        end else begin
            r_fb_s1 <= {cpu_halt, clk_out};
            r_fb_s2 <= r_fb_s1;
        end
    end

    assign w_halt_s = r_fb_s2[1];
    assign w_clk_s  = r_fb_s2[0];

    // Divider/processor reset pulse: started by reset release, restarted by btn_rst
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_reset <= 1'b1;
            r_rp_cnt    <= '0;
        end else if (w_rst_p) begin
            r_div_reset <= 1'b1;
            r_rp_cnt    <= '0;
        end else if (r_div_reset) begin
            if (r_rp_cnt == RP_LAST) begin
                r_div_reset <= 1'b0;
            end else begin
                r_rp_cnt <= r_rp_cnt + RP_W'(1);
            end
        end
    end

    // Frequency select advances on every freq pulse, independent of the FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_freq <= FREQ_INIT;
        end else if (w_freq_p) begin
            r_freq <= r_freq + 2'd1;
        end
    end

    // RUN / HALTED / single-step FSM; outputs are loaded together with the next state
    always_ff @(posedge clk) begin
        if (!reset || w_rst_p || r_div_reset) begin
            r_state    <= S_HALTED;
            r_halt     <= HALT_HOLD;
            r_running  <= 1'b0;
            r_stepping <= 1'b0;
        end else begin
            case (r_state)
                S_HALTED: begin
                    if (w_run_p) begin
                        r_state   <= S_RUN;
                        r_halt    <= HALT_RUN;
                        r_running <= 1'b1;
                    end else if (w_step_p) begin
                        r_state    <= S_STEP_FALL;
                        r_halt     <= HALT_RUN;
                        r_stepping <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_run_p || w_halt_s) begin
                        r_state   <= S_HALTED;
                        r_halt    <= HALT_HOLD;
                        r_running <= 1'b0;
                    end
                end
                S_STEP_FALL: begin
                    if (!w_clk_s) begin
                        r_state <= S_STEP_RISE;
                    end
                end
                S_STEP_RISE: begin
                    // Freeze the divider right after the single processor rising edge
                    if (w_clk_s) begin
                        r_state    <= S_HALTED;
                        r_halt     <= HALT_HOLD;
                        r_stepping <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_HALTED;
                    r_halt     <= HALT_HOLD;
                    r_running  <= 1'b0;
                    r_stepping <= 1'b0;
                end
            endcase
        end
    end

    assign freq      = r_freq;
    assign Halt      = r_halt;
    assign div_reset = r_div_reset;
    assign running   = r_running;
    assign stepping  = r_stepping;

endmodule

// File: tb/tb_clock_panel_ctrl.sv
// Testbench for clock_panel_ctrl with a small model clock divider on clk_out.
module tb_clock_panel_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RSTP = 16;
    localparam logic [1:0]  DIV_TC = 2'd3;   // divider model terminal count: half period of 4 clk

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_freq, btn_run, btn_step, btn_rst, cpu_halt;
    logic       clk_out;
    logic [1:0] freq;
    logic [1:0] Halt;
    logic       div_reset, running, stepping;

    int n_checks = 0;
    int n_fail   = 0;

    clock_panel_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .RST_PULSE_CYCLES(RSTP),
        .FREQ_INIT       (2'b00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_freq (btn_freq),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_rst  (btn_rst),
        .cpu_halt (cpu_halt),
        .clk_out  (clk_out),
        .freq     (freq),
        .Halt     (Halt),
        .div_reset(div_reset),
        .running  (running),
        .stepping (stepping)
    );

    always #5 clk = ~clk;

    // Model divider: toggles every DIV_TC+1 clocks, held high while halted or in reset
    logic       m_clk = 1'b1;
    logic       m_clk_d = 1'b1;
    logic [1:0] m_cnt = 2'd0;
    int         n_rise = 0;
    int         n_fall = 0;

    always @(posedge clk) begin
        if (div_reset === 1'b1 || Halt === 2'b10) begin
            m_clk <= 1'b1;
            m_cnt <= 2'd0;
        end else if (m_cnt == DIV_TC) begin
            m_clk <= ~m_clk;
            m_cnt <= 2'd0;
        end else begin
            m_cnt <= m_cnt + 2'd1;
        end
    end

    always @(posedge clk) begin
        m_clk_d <= m_clk;
        if (m_clk && !m_clk_d) n_rise <= n_rise + 1;
        if (!m_clk && m_clk_d) n_fall <= n_fall + 1;
    end

    assign clk_out = m_clk;

    typedef struct {
        logic [2:0] btn;        // {step, run, freq}
        logic [1:0] e_freq;
        logic [1:0] e_halt;
        logic       e_running;
        logic       e_stepping;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        {btn_step, btn_run, btn_freq} = m;
        repeat (7) tick();
    endtask

    task automatic release_btns();
        repeat (3) tick();
        {btn_step, btn_run, btn_freq} = 3'b000;
        repeat (10) tick();
    endtask

    initial begin
        int r0, f0, bad;

        vecs[0] = '{3'b001, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 2'b11, 2'b10, 1'b0, 1'b0};
        vecs[2] = '{3'b001, 2'b00, 2'b10, 1'b0, 1'b0};
        vecs[3] = '{3'b001, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[4] = '{3'b010, 2'b01, 2'b00, 1'b1, 1'b0};
        vecs[5] = '{3'b010, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 2'b01, 2'b00, 1'b1, 1'b0};
        vecs[7] = '{3'b010, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[8] = '{3'b011, 2'b10, 2'b00, 1'b1, 1'b0};
        vecs[9] = '{3'b010, 2'b10, 2'b10, 1'b0, 1'b0};

        reset = 1'b0;
        {btn_freq, btn_run, btn_step, btn_rst, cpu_halt} = 5'b0;

        // Power-up: reset values, then a 16-cycle div_reset pulse
        repeat (3) tick();
        chk("reset_vals", {freq, Halt, running, stepping, div_reset}, 7'b00_10_001);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("pwr_div_reset_%0d", i), div_reset, (i < 16) ? 1 : 0);
        end
        chk("pwr_idle", {freq, Halt, running, stepping}, 6'b00_10_00);

        // Short glitch is rejected
        btn_freq = 1'b1;
        repeat (3) tick();
        btn_freq = 1'b0;
        repeat (10) tick();
        chk("glitch_freq", freq, 2'b00);

        // Accepted press: freq changes exactly 7 edges after the raw edge
        btn_freq = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("latency_%0d", i), freq, (i < 7) ? 2'b00 : 2'b01);
        end
        repeat (3) tick();
        btn_freq = 1'b0;
        repeat (10) tick();

        // Table: freq wrap, run toggle, run+step priority, freq+run together
        for (int v = 0; v < 10; v++) begin
            press(vecs[v].btn);
            chk($sformatf("vec%0d_edge", v), {freq, Halt, running, stepping},
                {vecs[v].e_freq, vecs[v].e_halt, vecs[v].e_running, vecs[v].e_stepping});
            release_btns();
            chk($sformatf("vec%0d_settled", v), {freq, Halt, running, stepping},
                {vecs[v].e_freq, vecs[v].e_halt, vecs[v].e_running, vecs[v].e_stepping});
        end

        // cpu_halt forces HALTED within 3 clocks
        press(3'b010);
        chk("run_enter", {running, Halt}, 3'b1_00);
        release_btns();
        cpu_halt = 1'b1;
        repeat (2) tick();
        chk("cpu_halt_t2", {running, Halt}, 3'b1_00);
        tick();
        chk("cpu_halt_t3", {running, Halt}, 3'b0_10);
        // Run press with cpu_halt still high: one cycle of RUN
        btn_run = 1'b1;
        repeat (7) tick();
        chk("run_while_halt_enter", {running, Halt}, 3'b1_00);
        tick();
        chk("run_while_halt_exit", {running, Halt}, 3'b0_10);
        release_btns();
        cpu_halt = 1'b0;
        repeat (3) tick();

        // Single step; a second step press lands while stepping and is ignored
        r0 = n_rise;
        f0 = n_fall;
        btn_step = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j == 7)  chk("step_start", {stepping, Halt}, 3'b1_00);
            if (j == 12) chk("step_fall_phase", {stepping, Halt}, 3'b1_00);
            if (j == 16) chk("step_rise_phase", {stepping, Halt}, 3'b1_00);
            if (j == 18) chk("step_done", {stepping, Halt, running}, 4'b0_10_0);
            if (j == 5)  btn_step = 1'b0;
            if (j == 9)  btn_step = 1'b1;
            if (j == 17) btn_step = 1'b0;
        end
        chk("step_rises", n_rise - r0, 1);
        chk("step_falls", n_fall - f0, 1);
        bad = 0;
        for (int j = 0; j < 200; j++) begin
            tick();
            if (clk_out !== 1'b1 || Halt !== 2'b10 || stepping !== 1'b0) bad++;
        end
        chk("step_hold_high", bad, 0);
        chk("step_rises_after_hold", n_rise - r0, 1);

        // btn_rst during STEP_RISE: pulse restarts, FSM halted, freq kept
        btn_step = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j == 7)  chk("rst_step_start", stepping, 1'b1);
            if (j == 15) chk("rst_pre", {div_reset, stepping}, 2'b01);
            if (j == 16) chk("rst_edge", {div_reset, stepping, running, Halt, freq}, 7'b1_0_0_10_10);
            if (j >= 17 && j <= 32)
                chk($sformatf("rst_pulse_%0d", j), div_reset, (j < 32) ? 1 : 0);
            if (j == 5)  btn_step = 1'b0;
            if (j == 9)  btn_rst = 1'b1;
            if (j == 17) btn_rst = 1'b0;
        end
        chk("rst_after", {freq, Halt, running, stepping}, 6'b10_10_00);

        // Synchronous reset while running
        press(3'b010);
        chk("run_before_reset", running, 1'b1);
        release_btns();
        reset = 1'b0;
        tick();
        chk("midrun_reset", {freq, Halt, running, stepping, div_reset}, 7'b00_10_001);
        reset = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_panel_ctrl.md
Name: clock_panel_ctrl

Overview:
- Front-panel controller that sits directly upstream of the processor clock divider and drives its freq, Halt and reset inputs.
- Debounces raw board pushbuttons and cycles the divider frequency select.
- Runs a RUN/HALT/single-step state machine, using the divider's clk_out as feedback so that one step equals exactly one full processor clock period.
- Generates the divider/processor reset pulse at power-up and on request.

Parameters:
DEBOUNCE_CYCLES, 250000, clk cycles a synchronized button level must stay stable before it is accepted (5 ms at 50 MHz)
RST_PULSE_CYCLES, 16, clk cycles div_reset is held high after reset release or a reset-button press
FREQ_INIT, 2'b00, freq value after reset

Ports:
clk  in  1  board clock; same clock as the divider
reset  in  1  synchronous, active-low reset
btn_freq  in  1  raw pushbutton, active-high, asynchronous: advance freq
btn_run  in  1  raw pushbutton, active-high, asynchronous: toggle RUN/HALTED
btn_step  in  1  raw pushbutton, active-high, asynchronous: single step while halted
btn_rst  in  1  raw pushbutton, active-high, asynchronous: reset divider and processor
cpu_halt  in  1  level from the processor (HALT instruction retired); forces HALTED
clk_out  in  1  divider output, fed back
freq  out  2  divider frequency select
Halt  out  2  divider halt control: 2'b00 = clocking, 2'b10 = hold clk_out high
div_reset  out  1  active-high reset to the divider and processor
running  out  1  1 in RUN state (LED)
stepping  out  1  1 while a single step is in progress (LED)

Behaviour:
- Reset: all state is cleared on the clk edge where reset==0.
  - Output values during reset: freq=FREQ_INIT, Halt=2'b10, running=0, stepping=0, div_reset=1.
  - Debounce counters=0; accepted button levels=0; FSM=HALTED.
- div_reset timing:
  - Held 1 for RST_PULSE_CYCLES clk cycles after reset deasserts, then drops to 0.
  - A debounced btn_rst rising edge restarts the same pulse.
  - During the pulse the FSM is forced to HALTED, while freq is preserved.
- Input synchronization:
  - Each button passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized level differs from the accepted level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A rising edge of the accepted level produces a one-clk pulse. Falling edges produce nothing.
  - clk_out and cpu_halt also pass through 2-flop synchronizers; they are not debounced.
- Button-to-output latency: from raw edge to the action pulse is 2 sync cycles + DEBOUNCE_CYCLES cycles. The resulting output change appears on the following clk edge.
- freq: each freq pulse advances 00→01→10→11→00, wrapping. This is accepted in every FSM state.
- FSM states:
  - HALTED: Halt=10, running=0, stepping=0.
    - run pulse → RUN.
    - step pulse → STEP_FALL.
    - If both pulse on the same cycle, run wins.
  - RUN: Halt=00, running=1.
    - run pulse, or synced cpu_halt==1 → HALTED.
    - step pulses are ignored.
  - STEP_FALL: Halt=00, stepping=1. Stays here until synced clk_out==0, then → STEP_RISE.
  - STEP_RISE: Halt=00, stepping=1. Stays here until synced clk_out==1, then → HALTED with Halt=10 on the same transition.
    - The divider therefore freezes with clk_out high after exactly one processor rising edge.
  - Run/step pulses in STEP_* are ignored; a step cannot be aborted except by reset or btn_rst.
  - cpu_halt is ignored in STEP_* and HALTED.
    - A run pulse while cpu_halt is still 1 enters RUN for one cycle, then returns to HALTED.
- Simultaneous events:
  - A freq pulse combined with any FSM event: both take effect on the same edge.
  - btn_rst takes priority over all FSM events.
- Outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- Power-up (DEBOUNCE_CYCLES=4, RST_PULSE_CYCLES=16 for sim): hold reset low 3 cycles, release.
  - Required: freq=00, Halt=10, div_reset=1 for exactly 16 clk cycles, then 0; running=0.
- Debounce: glitch btn_freq high for 3 cycles → freq unchanged.
  - Then hold it high 10 cycles → freq=01 exactly 2+4+1 cycles after the raw edge.
  - Press 4 more times → 10, 11, 00, 01 (wrap).
- Run/halt: press btn_run → Halt=00, running=1.
  - Assert cpu_halt → Halt=10 within 3 clk cycles.
  - Press btn_run with cpu_halt still 1 → returns to HALTED one cycle after entering RUN.
- Single step: from HALTED with a model divider (N=3), press btn_step → stepping=1, Halt=00.
  - Required: exactly one rising edge of clk_out, after which Halt=10 and clk_out stays high for 200 cycles.
  - A btn_step press while stepping=1 produces no second edge.
- Reset mid-step: in STEP_RISE, press btn_rst → div_reset pulse of 16 cycles, FSM=HALTED, Halt=10, stepping=0, freq unchanged.
  - Then drive reset low mid-run → all outputs at their reset values on the next edge.
- Priority: in HALTED, pulse run and step on the same cycle → RUN with no step.
  - In HALTED, pulse freq and run together → freq advances and running=1 on the same edge.
